// File: rtl/clause_eval_fetch_if.sv
// Clause-database read port seen from the clause evaluator: active-low request,
// read/write strobes, word address, read data and the database's ready/busy toggle.
interface clause_eval_fetch_if #(
    parameter int data_size    = 8,
    parameter int address_size = 8
);
    logic                    db_mem_request;
    logic                    db_data_read;
    logic                    db_data_write;
    logic [address_size-1:0] db_address;
    logic [data_size-1:0]    db_d_out;
    logic                    db_mem_work;

    modport master (
        output db_mem_request, db_data_read, db_data_write, db_address,
        input  db_d_out, db_mem_work
    );

    modport slave (
        input  db_mem_request, db_data_read, db_data_write, db_address,
        output db_d_out, db_mem_work
    );
endinterface

// File: rtl/clause_eval_fetch.sv
// Walks one clause of the database a literal at a time and classifies it against
// the current assignment as SATISFIED, UNIT, CONFLICT or UNRESOLVED.
module clause_eval_fetch #(
    parameter int data_size    = 8,
    parameter int address_size = 8,
    parameter int num_vars     = 16,
    parameter int max_len      = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [address_size-1:0] start_addr,
    input  logic [num_vars-1:0]     assign_val,
    input  logic [num_vars-1:0]     assign_def,
    clause_eval_fetch_if.master     db,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              status,
    output logic [data_size-1:0]    implied_lit,
    output logic                    range_err
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] GAP     = 3'd3;
    localparam logic [2:0] REPORT  = 3'd4;

    localparam int CNT_W = $clog2(max_len + 1);

    logic [2:0]              state_reg;
    logic [address_size-1:0] addr_reg;
    logic [CNT_W-1:0]        lit_cnt_reg;
    logic [1:0]              unas_cnt_reg;
    logic                    err_reg;
    logic                    sat_reg;
    logic [data_size-1:0]    held_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [1:0]              status_reg;
    logic [data_size-1:0]    implied_reg;
    logic                    range_err_reg;

    // Widened copies let any 7-bit index be looked up without an out-of-range select.
    logic [127:0] val_ext;
    logic [127:0] def_ext;
    logic [6:0]   lit_idx;
    logic         lit_neg;
    logic         lit_term;
    logic         lit_in_range;
    logic         lit_true;
    logic         lit_unas;
    logic         fetch_active;
    logic [1:0]   report_status;

    assign val_ext      = 128'(assign_val);
    assign def_ext      = 128'(assign_def);
    assign lit_idx      = db.db_d_out[6:0];
    assign lit_neg      = db.db_d_out[7];
    assign lit_term     = (lit_idx == 7'd0);
    assign lit_in_range = (lit_idx < 7'(num_vars));
    assign lit_true     = lit_in_range && def_ext[lit_idx] && (val_ext[lit_idx] ^ lit_neg);
    assign lit_unas     = lit_in_range && !def_ext[lit_idx];

    assign report_status = sat_reg              ? 2'b01 :
                           (unas_cnt_reg == 2'd0) ? 2'b11 :
                           (unas_cnt_reg == 2'd1) ? 2'b10 : 2'b00;

    // Request stays low from issue until the data word has been captured.
    assign fetch_active      = (state_reg == ISSUE) || (state_reg == CAPTURE);
    assign db.db_mem_request = !fetch_active;
    assign db.db_data_read   = fetch_active;
    assign db.db_data_write  = 1'b0;
    assign db.db_address     = addr_reg;

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign status      = status_reg;
    assign implied_lit = implied_reg;
    assign range_err   = range_err_reg;

    always_ff @(posedge clock) begin
        done_reg <= 1'b0;
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            lit_cnt_reg   <= '0;
            unas_cnt_reg  <= 2'd0;
            err_reg       <= 1'b0;
            sat_reg       <= 1'b0;
            held_reg      <= '0;
            busy_reg      <= 1'b0;
            status_reg    <= 2'b00;
            implied_reg   <= '0;
            range_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg     <= start_addr;
                        lit_cnt_reg  <= '0;
                        unas_cnt_reg <= 2'd0;
                        err_reg      <= 1'b0;
                        sat_reg      <= 1'b0;
                        held_reg     <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (db.db_mem_work) state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    if (!db.db_mem_work) begin
                        if (lit_term) begin
                            state_reg <= REPORT;
                        end else if (lit_true) begin
                            sat_reg   <= 1'b1;
                            state_reg <= REPORT;
                        end else begin
                            // Out-of-range literals are flagged and then treated as false.
                            if (!lit_in_range) begin
                                err_reg <= 1'b1;
                            end else if (lit_unas) begin
                                if (unas_cnt_reg == 2'd0) held_reg <= db.db_d_out;
                                if (unas_cnt_reg != 2'd2) unas_cnt_reg <= unas_cnt_reg + 2'd1;
                            end
                            lit_cnt_reg <= lit_cnt_reg + 1'b1;
                            addr_reg    <= addr_reg + 1'b1;
                            state_reg   <= (lit_cnt_reg == CNT_W'(max_len - 1)) ? REPORT : GAP;
                        end
                    end
                end
                GAP: begin
                    state_reg <= ISSUE;
                end
                REPORT: begin
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b0;
                    status_reg    <= report_status;
                    implied_reg   <= (report_status == 2'b10) ? held_reg : '0;
                    range_err_reg <= err_reg;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/clause_eval_fetch.md
Name: clause_eval_fetch

Overview:
- Downstream consumer of the clause database in the hardware BCP path.
- On a start pulse it walks one clause in the database, reading one literal word per memory transaction over the database's request/mem_work handshake.
- Evaluates each literal against the current variable assignment and reports SATISFIED, UNIT (with the implied literal), CONFLICT or UNRESOLVED to the BCP controller.

Parameters:
- data_size, 8, literal word width; the encoding below requires 8.
- address_size, 8, clause database address width.
- num_vars, 16, number of variables in the assignment vectors (max 127).
- max_len, 8, maximum literals per clause; 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to evaluate a clause; ignored while busy=1.
- start_addr  in  address_size  database address of the clause's first literal.
- assign_val  in  num_vars  value of each variable; bit i = variable i.
- assign_def  in  num_vars  1 = variable i assigned.
- db_mem_request  out  1  active-low request to the database.
- db_data_read  out  1  read strobe; high whenever db_mem_request=0.
- db_data_write  out  1  constant 0.
- db_address  out  address_size  word address.
- db_d_out  in  data_size  database read data.
- db_mem_work  in  1  database ready/busy toggle.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse; status and implied_lit valid in that cycle.
- status  out  2  00 UNRESOLVED, 01 SATISFIED, 10 UNIT, 11 CONFLICT.
- implied_lit  out  data_size  literal that must become true; valid when status=UNIT, else 0.
- range_err  out  1  set with done if a literal named a variable >= num_vars.

Behaviour:
- Literal word: bit7 = negated, bits[6:0] = variable index. Index 0 is the end-of-clause terminator; variables are 1..num_vars-1.
- Literal value: assign_val[idx] XOR bit7. Unassigned when assign_def[idx]=0. Assignment inputs are sampled in the cycle each literal is captured.
- Reset state:
  - busy=0, done=0, status=00, implied_lit=0, range_err=0.
  - db_mem_request=1, db_data_read=0, db_address=0.
  - FSM in IDLE; internal counters cleared.
- IDLE:
  - On start=1, latch start_addr into db_address.
  - Clear unassigned count (2-bit, saturating at 2), literal count and the err flag.
  - Set busy=1 and go to ISSUE.
- ISSUE:
  - Drive db_mem_request=0 and db_data_read=1.
  - When db_mem_work=1 at a clock edge, the database performs the read at that edge; go to CAPTURE.
  - While db_mem_work=0, hold the request and stay in ISSUE.
- CAPTURE:
  - Wait for db_mem_work=0; db_d_out is valid in that cycle only. Capture it and deassert db_mem_request at the same edge.
  - Evaluate the captured word:
    - Terminator: go to REPORT.
    - idx >= num_vars: set err, treat the literal as false, continue.
    - Literal true: status SATISFIED; stop fetching and go to REPORT.
    - Literal unassigned: increment the saturating count and keep the literal in a holding register if the count was 0.
    - Literal false: no action.
  - Increment the literal count and db_address (wraps modulo 2^address_size).
  - If the literal count reaches max_len, go to REPORT; otherwise go to GAP.
- GAP: one cycle with db_mem_request=1 so the database can re-arm mem_work; then go to ISSUE.
- REPORT: one cycle.
  - done=1, busy=0 at the next edge.
  - status priority: SATISFIED if any true literal was found; else count 0 gives CONFLICT (an empty clause is also CONFLICT), count 1 gives UNIT with implied_lit = held literal, count 2 gives UNRESOLVED.
  - range_err = err.
  - Return to IDLE. status, implied_lit and range_err hold until the next start.
  - start arriving in the REPORT cycle is ignored.
- Throughput: 3 cycles per literal when the database is immediately ready, plus 1 start cycle and 1 report cycle.
- Reset mid-operation: at the next edge return to IDLE with reset values and deassert the request. Any database transaction in flight is abandoned, and the next read restarts the handshake.

Test Plan:
- Clause at addr 0x10 = {0x01, 0x82, 0x00}, assign_def=0x0006, assign_val=0x0000 -> var1 false, var2 negated true -> done with status=01; exactly 2 reads issued; 0x00 not fetched.
- Clause {0x01, 0x03, 0x00}, var1 defined false, var3 undefined -> status=10, implied_lit=0x03, 3 reads.
- Clause {0x81, 0x02, 0x00}, var1 true, var2 false -> status=11, implied_lit=0x00; single word 0x00 -> status=11 after 1 read.
- Clause {0x04, 0x05, 0x06, 0x00}, none defined -> status=00; start pulsed mid-run is ignored and busy stays 1.
- Clause at 0xFF = {0x01, 0x00 at 0x00}, var1 undefined -> addresses 0xFF then 0x00 (wrap); status=10. With max_len=1, only one read -> status=10.
- Word 0x25 with num_vars=16 -> range_err=1 and the literal counted false. Reset asserted while in CAPTURE -> next cycle busy=0, db_mem_request=1, status=00.
